acsu_folded_radix: RTL and testbench
====================================

Name: acsu_folded_radix

Overview:
- Parametrised, time-folded Add-Compare-Select unit for a rate-k/n shift-register trellis with 2^M states and 2^K branches per state.
- Holds all path metrics internally, double-buffered.
- Processes one trellis step per accepted branch-metric vector, using P ACS lanes over 2^M/P cycles.
- Adds threshold normalisation, saturation, a best-state output and an init/handshake interface.
- Sits between the branch-metric unit and survivor memory/traceback in the Viterbi decoder.

Parameters:
- M, 3, state bits; N = 2^M states.
- K, 2, input bits per step; 2^K branches per state; K <= M.
- BMW, 4, branch-metric width (unsigned).
- W, 8, path-metric width (unsigned).
- P, 2, ACS lanes; power of 2; P divides N.
- NORM_THRESH, 128, normalisation threshold; must be < 2^W.
- INIT_BIAS, 64, initial metric of states other than 0.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- init, input, 1: reload initial metrics; honoured in IDLE only.
- bm_valid, input, 1: branch-metric vector valid.
- bm_ready, output, 1: high in IDLE when init=0.
- bm_in, input, N*2^K*BMW: metric for branch b into state s' at [(s'*2^K+b)*BMW +: BMW].
- dec_valid, output, 1: one-cycle pulse; a trellis step has completed.
- dec_out, output, N*K: chosen branch index b for state s' at [s'*K +: K]; held until the next step.
- pm_out, output, N*W: current committed path metrics.
- best_state, output, M: lowest-metric state of the last step.
- best_metric, output, W: metric of best_state.
- norm_applied, output, 1: the last step subtracted NORM_THRESH.

Behaviour:
- Trellis definition:
  - Next state = ((p<<K) | u) mod N.
  - Predecessor of s' via branch b is p = (s'>>K) | (b<<(M-K)).
- Add-compare-select:
  - cand_b = pm_old[p] + bm[s'][b] - norm_sub, computed at W+1 bits.
  - Saturate at 2^W-1.
  - Select the minimum candidate; on ties the lowest b wins.
  - Decision = winning b.
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - bm_ready = !init.
  - If init: pm[0]=0, pm[s]=INIT_BIAS for s≠0, norm_sub=0; no accept.
  - Else if bm_valid: capture bm_in, set cnt=0, go to BUSY.
  - norm_sub is latched at accept: NORM_THRESH if best_metric >= NORM_THRESH, else 0.
- BUSY:
  - Each cycle, lanes 0..P-1 process states cnt*P+lane, writing pm_new and decision registers.
  - Running min/argmin is updated, lowest index on tie.
  - On the last cycle (cnt = N/P-1): pm_old <= pm_new including the final slice, update best_state/best_metric/norm_applied, go to DONE.
- DONE:
  - dec_valid=1 for exactly one cycle.
  - dec_out, pm_out and best_* are valid in this cycle and stay stable afterwards.
  - Next edge goes to IDLE.
- Latency and throughput:
  - Accepting edge e0; dec_valid is high in the cycle after edge e(N/P).
  - Minimum step period is N/P+2 cycles.
  - Defaults: 4 BUSY cycles, period 6.
- bm_in is ignored outside IDLE; init is ignored in BUSY and DONE.
- Reset values:
  - bm_ready=1, dec_valid=0, dec_out=0, best_state=0, best_metric=0, norm_applied=0.
  - pm_out: state 0 = 0, all others = INIT_BIAS.
  - FSM in IDLE, cnt=0.
- Reset mid-BUSY:
  - Immediate return to reset values.
  - No dec_valid pulse; the partial step is discarded.

Decomposition:
- Shared include/package holds:
  - Default widths.
  - Predecessor-index function.
  - FSM state encodings.
  - Saturation constant 2^W-1.
- One sub-module, acs_radix_lane: combinational 2^K-way add/saturate/compare-select with lowest-index tie-break.
- The top instantiates P lanes; it owns the FSM, counter, metric buffers and min tracker.

Test Plan:
- Reset, then release: bm_ready=1, dec_valid=0, pm_out={0,64,64,64,64,64,64,64}.
- init pulse, then one step with all bm=0:
  - dec_valid in the cycle after edge 4 from accept.
  - pm_out={0,0,0,0,64,64,64,64}, dec_out all 0, best_state=0, best_metric=0.
- After init, all pm=64 except pm[0]; drive bm for s'=5 as b0..b3=9,3,7,3 (predecessors 1,3,5,7):
  - pm[5]=67.
  - dec[5]=1 (tie with b3 resolved to lowest index).
- Uniform bm=15 on all branches from init, repeated steps:
  - Min after step 9 = 135 with norm_applied=0.
  - Step 10: norm_applied=1, best_metric=22.
- Bench config INIT_BIAS=250, init, all bm=15:
  - States 4..7 saturate to 255.
  - States 0..3 = 15.
- Reset asserted on BUSY cycle 2:
  - Outputs return to reset values asynchronously; no dec_valid.
  - After release, bm_valid is accepted on the first IDLE edge.
- init held high while bm_valid=1 in IDLE: bm_ready=0, no accept, metrics reloaded.

Source files
------------

// File: rtl/acsu_folded_radix_pkg.sv
// Shared definitions for the folded add-compare-select unit.
// Holds the default trellis widths, the FSM state encoding, the saturation
// constant helper and the predecessor-index function. The top, its interface
// and the ACS lane all import it.
package acsu_folded_radix_pkg;

  localparam int DEF_M           = 3;
  localparam int DEF_K           = 2;
  localparam int DEF_BMW         = 4;
  localparam int DEF_W           = 8;
  localparam int DEF_P           = 2;
  localparam int DEF_NORM_THRESH = 128;
  localparam int DEF_INIT_BIAS   = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } acsu_state_e;

  // Largest value a w-bit unsigned path metric can hold.
  function automatic longint unsigned sat_value(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // State that reaches s via branch b: the shift register drops K bits and
  // the branch index supplies the oldest bits.
  function automatic int unsigned pred_state(input int unsigned s, input int unsigned b,
                                             input int m, input int k);
    return ((s >> k) | (b << (m - k))) & ((32'd1 << m) - 32'd1);
  endfunction

endpackage

// File: rtl/acsu_folded_radix_if.sv
// Handshake and metric bus between the branch-metric unit, the ACSU and the
// survivor memory.
//   i_init, i_bm_valid, i_bm_in : driven by the producer (master)
//   o_bm_ready                  : ACSU can take a branch-metric vector
//   o_dec_valid, o_dec_out      : one-cycle step-complete pulse and decisions
//   o_pm_out                    : committed path metrics
//   o_best_state/o_best_metric  : lowest-metric state of the last step
//   o_norm_applied              : last step subtracted the threshold
interface acsu_folded_radix_if import acsu_folded_radix_pkg::*; #(
  parameter int M   = DEF_M,
  parameter int K   = DEF_K,
  parameter int BMW = DEF_BMW,
  parameter int W   = DEF_W
);
  localparam int N  = 1 << M;
  localparam int NB = 1 << K;

  logic                  i_init;
  logic                  i_bm_valid;
  logic [N*NB*BMW-1:0]   i_bm_in;
  logic                  o_bm_ready;
  logic                  o_dec_valid;
  logic [N*K-1:0]        o_dec_out;
  logic [N*W-1:0]        o_pm_out;
  logic [M-1:0]          o_best_state;
  logic [W-1:0]          o_best_metric;
  logic                  o_norm_applied;

  modport master (
    output i_init, i_bm_valid, i_bm_in,
    input  o_bm_ready, o_dec_valid, o_dec_out, o_pm_out,
           o_best_state, o_best_metric, o_norm_applied
  );

  modport slave (
    input  i_init, i_bm_valid, i_bm_in,
    output o_bm_ready, o_dec_valid, o_dec_out, o_pm_out,
           o_best_state, o_best_metric, o_norm_applied
  );

endinterface

// File: rtl/acsu_folded_radix_acs_radix_lane.sv
// One combinational ACS lane: 2^K-way add, saturate, compare and select.
//   i_pm     : predecessor metrics, branch b at [b*W +: W]
//   i_bm     : branch metrics, branch b at [b*BMW +: BMW]
//   i_sub    : normalisation amount removed from every candidate
//   o_metric : surviving (minimum) candidate
//   o_dec    : winning branch index, lowest index on ties
module acs_radix_lane import acsu_folded_radix_pkg::*; #(
  parameter int K   = DEF_K,
  parameter int BMW = DEF_BMW,
  parameter int W   = DEF_W
) (
  input  logic [(1<<K)*W-1:0]   i_pm,
  input  logic [(1<<K)*BMW-1:0] i_bm,
  input  logic [W-1:0]          i_sub,
  output logic [W-1:0]          o_metric,
  output logic [K-1:0]          o_dec
);
  localparam int NB = 1 << K;
  localparam logic [W:0] LP_SAT = (W+1)'(sat_value(W));

  logic [W:0] w_cand [NB];
  logic [W:0] w_best;

  // One extra bit holds the carry; the subtraction never underflows because
  // every metric is at least the previous minimum, which is at least i_sub.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      w_cand[b] = {1'b0, i_pm[b*W +: W]} + (W+1)'(i_bm[b*BMW +: BMW]) - {1'b0, i_sub};
      if (w_cand[b] > LP_SAT) w_cand[b] = LP_SAT;
    end
  end

  // Strict less-than keeps the earlier (lower) branch on ties.
  always_comb begin
    w_best = w_cand[0];
    o_dec  = '0;
    for (int b = 1; b < NB; b++) begin
      if (w_cand[b] < w_best) begin
        w_best = w_cand[b];
        o_dec  = K'(b);
      end
    end
    o_metric = w_best[W-1:0];
  end

endmodule

// File: rtl/acsu_folded_radix.sv
// Time-folded add-compare-select unit for a 2^M-state, 2^K-branch trellis.
// P lanes sweep the states over N/P cycles per accepted branch-metric vector;
// path metrics are double-buffered (committed / in-progress).
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : handshake, branch metrics in; decisions, metrics, best state out
module acsu_folded_radix import acsu_folded_radix_pkg::*; #(
  parameter int M           = DEF_M,
  parameter int K           = DEF_K,
  parameter int BMW         = DEF_BMW,
  parameter int W           = DEF_W,
  parameter int P           = DEF_P,
  parameter int NORM_THRESH = DEF_NORM_THRESH,
  parameter int INIT_BIAS   = DEF_INIT_BIAS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  acsu_folded_radix_if.slave  bus
);
  localparam int N      = 1 << M;
  localparam int NB     = 1 << K;
  localparam int NSLICE = N / P;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(NSLICE - 1);
  localparam logic [W-1:0]  LP_SAT      = W'(sat_value(W));
  localparam logic [W-1:0]  LP_THRESH   = W'(NORM_THRESH);
  localparam logic [W-1:0]  LP_BIAS     = W'(INIT_BIAS);

  acsu_state_e        r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [W-1:0]       r_pm_old [N];
  logic [W-1:0]       r_pm_new [N];
  logic [K-1:0]       r_dec_work [N];
  logic [K-1:0]       r_dec_out [N];
  logic [BMW-1:0]     r_bm [N][NB];
  logic               r_norm_sub;
  logic [W-1:0]       r_min;
  logic [M-1:0]       r_argmin;
  logic [M-1:0]       r_best_state;
  logic [W-1:0]       r_best_metric;
  logic               r_norm_applied;

  logic               w_accept, w_init, w_last;
  logic [W-1:0]       w_sub;
  logic [M-1:0]       w_idx [P];
  logic [NB*W-1:0]    w_lane_pm [P];
  logic [NB*BMW-1:0]  w_lane_bm [P];
  logic [W-1:0]       w_lane_metric [P];
  logic [K-1:0]       w_lane_dec [P];
  logic [W-1:0]       w_pm_next [N];
  logic [K-1:0]       w_dec_next [N];
  logic [W-1:0]       w_min_next;
  logic [M-1:0]       w_argmin_next;

  assign w_last = (r_cnt == LP_CNT_LAST);
  assign w_sub  = r_norm_sub ? LP_THRESH : '0;

  // Gather predecessor metrics and captured branch metrics for this slice.
  always_comb begin
    for (int l = 0; l < P; l++) begin
      w_idx[l]     = M'(int'(r_cnt) * P + l);
      w_lane_pm[l] = '0;
      w_lane_bm[l] = '0;
      for (int b = 0; b < NB; b++) begin
        w_lane_pm[l][b*W +: W]     = r_pm_old[M'(pred_state(32'(w_idx[l]), b, M, K))];
        w_lane_bm[l][b*BMW +: BMW] = r_bm[w_idx[l]][K'(b)];
      end
    end
  end

  for (genvar l = 0; l < P; l++) begin : g_lane
    acs_radix_lane #(.K(K), .BMW(BMW), .W(W)) u_lane (
      .i_pm     (w_lane_pm[l]),
      .i_bm     (w_lane_bm[l]),
      .i_sub    (w_sub),
      .o_metric (w_lane_metric[l]),
      .o_dec    (w_lane_dec[l])
    );
  end

  // Merge this slice into the working buffers and the running minimum.
  // Lanes are visited in ascending state order, so strict less-than keeps
  // the lowest state index on ties across the whole sweep.
  always_comb begin
    w_pm_next     = r_pm_new;
    w_dec_next    = r_dec_work;
    w_min_next    = r_min;
    w_argmin_next = r_argmin;
    for (int l = 0; l < P; l++) begin
      w_pm_next[w_idx[l]]  = w_lane_metric[l];
      w_dec_next[w_idx[l]] = w_lane_dec[l];
      if (w_lane_metric[l] < w_min_next) begin
        w_min_next    = w_lane_metric[l];
        w_argmin_next = w_idx[l];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    w_init          = 1'b0;
    bus.o_bm_ready  = 1'b0;
    bus.o_dec_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        bus.o_bm_ready = !bus.i_init;
        if (bus.i_init) begin
          w_init = 1'b1;
        end else if (bus.i_bm_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: begin
        bus.o_dec_valid = 1'b1;
        w_state_nxt     = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_norm_sub     <= 1'b0;
      r_min          <= LP_SAT;
      r_argmin       <= '0;
      r_best_state   <= '0;
      r_best_metric  <= '0;
      r_norm_applied <= 1'b0;
      for (int s = 0; s < N; s++) begin
        r_pm_old[s]  <= (s == 0) ? '0 : LP_BIAS;
        r_dec_out[s] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      // Reloading puts state 0 at metric 0, which is then the true minimum;
      // the best-state record follows so the next step does not normalise
      // against a stale minimum.
      if (w_init) begin
        for (int s = 0; s < N; s++) r_pm_old[s] <= (s == 0) ? '0 : LP_BIAS;
        r_best_state   <= '0;
        r_best_metric  <= '0;
        r_norm_applied <= 1'b0;
      end
      if (w_accept) begin
        r_cnt      <= '0;
        r_norm_sub <= (r_best_metric >= LP_THRESH);
        r_min      <= LP_SAT;
        r_argmin   <= '0;
      end
      if (r_state == ST_BUSY) begin
        r_cnt    <= r_cnt + CW'(1);
        r_min    <= w_min_next;
        r_argmin <= w_argmin_next;
        if (w_last) begin
          r_cnt          <= '0;
          r_pm_old       <= w_pm_next;
          r_dec_out      <= w_dec_next;
          r_best_state   <= w_argmin_next;
          r_best_metric  <= w_min_next;
          r_norm_applied <= r_norm_sub;
        end
      end
    end
  end

  // Working buffers are fully rewritten every step before being committed.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int s = 0; s < N; s++)
        for (int b = 0; b < NB; b++)
          r_bm[s][b] <= bus.i_bm_in[(s*NB + b)*BMW +: BMW];
    end
    if (r_state == ST_BUSY) begin
      r_pm_new   <= w_pm_next;
      r_dec_work <= w_dec_next;
    end
  end

  always_comb begin
    bus.o_pm_out  = '0;
    bus.o_dec_out = '0;
    for (int s = 0; s < N; s++) begin
      bus.o_pm_out[s*W +: W]  = r_pm_old[s];
      bus.o_dec_out[s*K +: K] = r_dec_out[s];
    end
  end

  assign bus.o_best_state   = r_best_state;
  assign bus.o_best_metric  = r_best_metric;
  assign bus.o_norm_applied = r_norm_applied;

endmodule

// File: tb/tb_acsu_folded_radix.sv
module tb_acsu_folded_radix;
  localparam int M = 3, K = 2, BMW = 4, W = 8, P = 2;
  localparam int N = 8, NB = 4;

  logic clk, rst_n;
  int checks = 0;
  int failures = 0;

  acsu_folded_radix_if #(.M(M), .K(K), .BMW(BMW), .W(W)) ifa ();
  acsu_folded_radix_if #(.M(M), .K(K), .BMW(BMW), .W(W)) ifb ();

  acsu_folded_radix #(.M(M), .K(K), .BMW(BMW), .W(W), .P(P),
                      .NORM_THRESH(128), .INIT_BIAS(64)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifa));

  acsu_folded_radix #(.M(M), .K(K), .BMW(BMW), .W(W), .P(P),
                      .NORM_THRESH(128), .INIT_BIAS(250)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: whole-trellis step, no folding.
  int m_pm [N];
  int m_dec [N];
  int m_best_s, m_best_m;
  int m_norm;

  task automatic model_reset();
    for (int s = 0; s < N; s++) begin
      m_pm[s] = (s == 0) ? 0 : 64;
      m_dec[s] = 0;
    end
    m_best_s = 0; m_best_m = 0; m_norm = 0;
  endtask

  task automatic model_init();
    for (int s = 0; s < N; s++) m_pm[s] = (s == 0) ? 0 : 64;
    m_best_s = 0; m_best_m = 0; m_norm = 0;
  endtask

  task automatic model_step(input logic [127:0] bm);
    int sub, c, s, b, best, bi;
    int cand [N][NB];
    sub = (m_best_m >= 128) ? 128 : 0;
    // Enumerate forward transitions: p --u--> s', branch index = top bits of p.
    for (int p = 0; p < N; p++) begin
      for (int u = 0; u < NB; u++) begin
        s = ((p * NB) + u) % N;
        b = p / (N / NB);
        c = m_pm[p] + int'(bm[(s*NB + b)*BMW +: BMW]) - sub;
        if (c > 255) c = 255;
        cand[s][b] = c;
      end
    end
    for (int t = 0; t < N; t++) begin
      best = cand[t][0]; bi = 0;
      for (int j = 1; j < NB; j++)
        if (cand[t][j] < best) begin best = cand[t][j]; bi = j; end
      m_pm[t] = best; m_dec[t] = bi;
    end
    m_best_s = 0; m_best_m = m_pm[0];
    for (int t = 1; t < N; t++)
      if (m_pm[t] < m_best_m) begin m_best_m = m_pm[t]; m_best_s = t; end
    m_norm = (sub != 0) ? 1 : 0;
  endtask

  function automatic logic [63:0] m_pm_vec();
    logic [63:0] r;
    for (int s = 0; s < N; s++) r[s*8 +: 8] = 8'(m_pm[s]);
    return r;
  endfunction

  function automatic logic [15:0] m_dec_vec();
    logic [15:0] r;
    for (int s = 0; s < N; s++) r[s*2 +: 2] = 2'(m_dec[s]);
    return r;
  endfunction

  function automatic logic [127:0] rand_bm(input int lo);
    logic [127:0] v;
    for (int i = 0; i < N*NB; i++) v[i*4 +: 4] = 4'($urandom_range(15, lo));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_pm"}, 64'(ifa.o_pm_out), m_pm_vec());
    chk({tag, "_dec"}, 64'(ifa.o_dec_out), 64'(m_dec_vec()));
    chk({tag, "_best_state"}, 64'(ifa.o_best_state), 64'(m_best_s));
    chk({tag, "_best_metric"}, 64'(ifa.o_best_metric), 64'(m_best_m));
    chk({tag, "_norm"}, 64'(ifa.o_norm_applied), 64'(m_norm));
  endtask

  // Called right after the accepting edge.
  task automatic finish_step(input logic [127:0] bm, input string tag);
    int n;
    ifa.i_bm_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    model_step(bm);
    n = 0;
    while (!ifa.o_dec_valid && n < 20) begin tick(); n++; end
    chk({tag, "_latency"}, 64'(n), 64'd4);
    compare_all(tag);
    tick();
    chk({tag, "_pulse"}, 64'(ifa.o_dec_valid), 64'd0);
    chk({tag, "_hold_pm"}, 64'(ifa.o_pm_out), m_pm_vec());
  endtask

  task automatic step_a(input logic [127:0] bm, input string tag);
    int n;
    n = 0;
    while (!ifa.o_bm_ready && n < 20) begin tick(); n++; end
    chk({tag, "_ready"}, 64'(ifa.o_bm_ready), 64'd1);
    ifa.i_bm_valid = 1'b1;
    ifa.i_bm_in = bm;
    tick();
    ifa.i_bm_valid = 1'b0;
    finish_step(bm, tag);
  endtask

  task automatic init_a();
    ifa.i_init = 1'b1;
    tick();
    ifa.i_init = 1'b0;
    model_init();
  endtask

  typedef struct {
    logic [127:0] bm;
    logic [63:0]  pm;
    logic [15:0]  dec;
    logic [2:0]   bs;
    logic [7:0]   bmet;
  } vec_t;

  initial begin
    vec_t tbl [2];
    logic [127:0] bm, all15;
    int n;

    all15 = '1;
    tbl[0] = '{bm: 128'd0, pm: 64'h40404040_00000000, dec: 16'h0000, bs: 3'd0, bmet: 8'd0};
    tbl[1] = '{bm: (128'h3739 << 80), pm: 64'h40404340_00000000, dec: 16'h0400,
               bs: 3'd0, bmet: 8'd0};

    ifa.i_init = 0; ifa.i_bm_valid = 0; ifa.i_bm_in = '0;
    ifb.i_init = 0; ifb.i_bm_valid = 0; ifb.i_bm_in = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    model_reset();
    chk("rst_ready", 64'(ifa.o_bm_ready), 64'd1);
    chk("rst_dec_valid", 64'(ifa.o_dec_valid), 64'd0);
    chk("rst_pm", 64'(ifa.o_pm_out), 64'h40404040_40404000);
    compare_all("rst");

    // Known vectors from a fresh init.
    for (int i = 0; i < 2; i++) begin
      init_a();
      step_a(tbl[i].bm, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_pm_const", i), 64'(ifa.o_pm_out), tbl[i].pm);
      chk($sformatf("tbl%0d_dec_const", i), 64'(ifa.o_dec_out), 64'(tbl[i].dec));
      chk($sformatf("tbl%0d_bs_const", i), 64'(ifa.o_best_state), 64'(tbl[i].bs));
      chk($sformatf("tbl%0d_bm_const", i), 64'(ifa.o_best_metric), 64'(tbl[i].bmet));
    end

    // Uniform metrics: minimum grows by 15 until normalisation kicks in.
    init_a();
    for (int i = 1; i <= 10; i++) begin
      step_a(all15, $sformatf("uni%0d", i));
      if (i == 9) begin
        chk("uni9_best_const", 64'(ifa.o_best_metric), 64'd135);
        chk("uni9_norm_const", 64'(ifa.o_norm_applied), 64'd0);
      end
      if (i == 10) begin
        chk("uni10_best_const", 64'(ifa.o_best_metric), 64'd22);
        chk("uni10_norm_const", 64'(ifa.o_norm_applied), 64'd1);
      end
    end

    // Randomised steps against the model.
    init_a();
    for (int i = 0; i < 30; i++) step_a(rand_bm((i % 3 == 0) ? 0 : 8), $sformatf("rnd%0d", i));

    // init held together with bm_valid: no accept, metrics reloaded.
    ifa.i_init = 1'b1; ifa.i_bm_valid = 1'b1; ifa.i_bm_in = rand_bm(0);
    #1;
    chk("inithold_ready", 64'(ifa.o_bm_ready), 64'd0);
    tick();
    chk("inithold_ready2", 64'(ifa.o_bm_ready), 64'd0);
    ifa.i_init = 1'b0; ifa.i_bm_valid = 1'b0;
    #1;
    model_init();
    chk("inithold_idle", 64'(ifa.o_bm_ready), 64'd1);
    compare_all("inithold");

    // Reset during the second BUSY cycle.
    step_a(rand_bm(0), "prerst");
    ifa.i_bm_valid = 1'b1; ifa.i_bm_in = rand_bm(0);
    tick();
    ifa.i_bm_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_ready", 64'(ifa.o_bm_ready), 64'd1);
    chk("midrst_dec_valid", 64'(ifa.o_dec_valid), 64'd0);
    compare_all("midrst");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_pulse", 64'(ifa.o_dec_valid), 64'd0);
    end
    rst_n = 1'b1;
    bm = rand_bm(0);
    ifa.i_bm_valid = 1'b1; ifa.i_bm_in = bm;
    tick();
    ifa.i_bm_valid = 1'b0;
    chk("postrst_accept", 64'(ifa.o_bm_ready), 64'd0);
    finish_step(bm, "postrst");

    // Saturation with a large initial bias.
    ifb.i_init = 1'b1;
    tick();
    ifb.i_init = 1'b0; ifb.i_bm_valid = 1'b1; ifb.i_bm_in = all15;
    tick();
    ifb.i_bm_valid = 1'b0;
    n = 0;
    while (!ifb.o_dec_valid && n < 20) begin tick(); n++; end
    chk("sat_latency", 64'(n), 64'd4);
    chk("sat_pm", 64'(ifb.o_pm_out), 64'hFFFFFFFF_0F0F0F0F);
    chk("sat_dec", 64'(ifb.o_dec_out), 64'd0);
    chk("sat_best_state", 64'(ifb.o_best_state), 64'd0);
    chk("sat_best_metric", 64'(ifb.o_best_metric), 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
